pc_unit: RTL and testbench

//   Parametrised program-counter unit for the RV32I fetch stage. Holds the PC;

---
 rtl/pc_unit.sv | 108 ++++++++++
 tb/tb_pc_unit.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/pc_unit.sv
// Program-counter unit for the RV32I fetch stage: sequential advance on fetch
// handshake, redirect/trap loading with alignment check, and BOOT/RUN/HALT control.
module pc_unit #(
   parameter int unsigned          XLEN         = 32,
   parameter logic [XLEN-1:0]      RESET_VECTOR = 32'h0000_0000,
   parameter logic [XLEN-1:0]      TRAP_VECTOR  = 32'h0000_0100,
   parameter int unsigned          INC_BYTES    = 4,
   parameter int unsigned          ALIGN_BITS   = 2
) (
   input  logic            Clk,
   input  logic            Reset,
   input  logic            Fetch_Ready,
   input  logic            Stall,
   input  logic            Redirect_Valid,
   input  logic [XLEN-1:0] Redirect_Target,
   input  logic            Trap_Valid,
   input  logic            Halt_Req,
   input  logic            Resume,
   output logic [XLEN-1:0] PC_Out,
   output logic [XLEN-1:0] PC_Plus_Out,
   output logic [XLEN-1:0] PC_Prev_Out,
   output logic            PC_Valid,
   output logic            Misalign_Err,
   output logic            Halted
);

   typedef enum logic [1:0] {
      BOOT = 2'd0,
      RUN  = 2'd1,
      HALT = 2'd2
   } state_t;

   // A zero-width check collapses to an all-zero mask, so ALIGN_BITS=0 never flags.
   localparam logic [XLEN-1:0] ALIGN_MASK = ~({XLEN{1'b1}} << ALIGN_BITS);
   localparam logic [XLEN-1:0] INC        = XLEN'(INC_BYTES);

   state_t          state_q, state_d;
   logic [XLEN-1:0] pc_q, pc_d;
   logic [XLEN-1:0] pc_prev_q, pc_prev_d;
   logic            misalign_q, misalign_d;

   logic            accept;
   logic            misaligned;
   logic [XLEN-1:0] pc_plus;

   assign pc_plus    = pc_q + INC;
   assign misaligned = |(Redirect_Target & ALIGN_MASK);
   assign accept     = (state_q == RUN) && Fetch_Ready && !Stall;

   always_comb begin
      pc_d       = pc_q;
      pc_prev_d  = pc_prev_q;
      misalign_d = 1'b0;
      state_d    = state_q;

      if (Trap_Valid) begin
         pc_d = TRAP_VECTOR;
      end else if (Redirect_Valid && misaligned) begin
         pc_d       = TRAP_VECTOR;
         misalign_d = 1'b1;
      end else if (Redirect_Valid) begin
         pc_d = Redirect_Target;
      end else if (accept) begin
         pc_d = pc_plus;
      end

      if (accept) begin
         pc_prev_d = pc_q;
      end

      unique case (state_q)
         BOOT: state_d = RUN;
         RUN: begin
            if (!Trap_Valid && !Redirect_Valid && Halt_Req) begin
               state_d = HALT;
            end
         end
         HALT: begin
            if (Trap_Valid || (Resume && !Halt_Req)) begin
               state_d = RUN;
            end
         end
         default: state_d = BOOT;
      endcase
   end

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state_q    <= BOOT;
         pc_q       <= RESET_VECTOR;
         pc_prev_q  <= RESET_VECTOR;
         misalign_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         pc_prev_q  <= pc_prev_d;
         misalign_q <= misalign_d;
      end
   end

   assign PC_Out       = pc_q;
   assign PC_Plus_Out  = pc_plus;
   assign PC_Prev_Out  = pc_prev_q;
   assign PC_Valid     = (state_q == RUN);
   assign Halted       = (state_q == HALT);
   assign Misalign_Err = misalign_q;

endmodule

// File: tb/tb_pc_unit.sv
// Directed bench for pc_unit: one default instance and one with the alignment
// check disabled, both driven by the same stimulus.
module tb_pc_unit;

   logic        Clk = 1'b0;
   logic        Reset;
   logic        Fetch_Ready, Stall, Redirect_Valid, Trap_Valid, Halt_Req, Resume;
   logic [31:0] Redirect_Target;

   logic [31:0] pc_a, plus_a, prev_a;
   logic        valid_a, err_a, halted_a;
   logic [31:0] pc_b, plus_b, prev_b;
   logic        valid_b, err_b, halted_b;

   int passed = 0;
   int total  = 0;

   always #5 Clk = ~Clk;

   pc_unit #(.XLEN(32), .RESET_VECTOR(32'h0), .TRAP_VECTOR(32'h100),
             .INC_BYTES(4), .ALIGN_BITS(2)) dut (
      .Clk(Clk), .Reset(Reset), .Fetch_Ready(Fetch_Ready), .Stall(Stall),
      .Redirect_Valid(Redirect_Valid), .Redirect_Target(Redirect_Target),
      .Trap_Valid(Trap_Valid), .Halt_Req(Halt_Req), .Resume(Resume),
      .PC_Out(pc_a), .PC_Plus_Out(plus_a), .PC_Prev_Out(prev_a),
      .PC_Valid(valid_a), .Misalign_Err(err_a), .Halted(halted_a)
   );

   pc_unit #(.XLEN(32), .RESET_VECTOR(32'h0), .TRAP_VECTOR(32'h100),
             .INC_BYTES(4), .ALIGN_BITS(0)) dut_noalign (
      .Clk(Clk), .Reset(Reset), .Fetch_Ready(Fetch_Ready), .Stall(Stall),
      .Redirect_Valid(Redirect_Valid), .Redirect_Target(Redirect_Target),
      .Trap_Valid(Trap_Valid), .Halt_Req(Halt_Req), .Resume(Resume),
      .PC_Out(pc_b), .PC_Plus_Out(plus_b), .PC_Prev_Out(prev_b),
      .PC_Valid(valid_b), .Misalign_Err(err_b), .Halted(halted_b)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   task automatic step();
      @(posedge Clk);
      #1;
   endtask

   task automatic chk_pc(input string tag, input logic [31:0] pc, input logic [31:0] prev);
      chk({tag, "_pc"}, pc_a, pc);
      chk({tag, "_prev"}, prev_a, prev);
   endtask

   initial begin
      Reset = 1'b1; Fetch_Ready = 1'b0; Stall = 1'b0; Redirect_Valid = 1'b0;
      Trap_Valid = 1'b0; Halt_Req = 1'b0; Resume = 1'b0; Redirect_Target = '0;
      #12;
      chk("rst_pc", pc_a, 32'h0);
      chk("rst_prev", prev_a, 32'h0);
      chk("rst_valid", {31'b0, valid_a}, 32'h0);
      chk("rst_err", {31'b0, err_a}, 32'h0);
      chk("rst_halted", {31'b0, halted_a}, 32'h0);
      chk("rst_plus", plus_a, 32'h4);
      Reset = 1'b0;
      Fetch_Ready = 1'b1;

      // BOOT -> RUN, then sequential fetch
      step(); chk("boot_valid", {31'b0, valid_a}, 32'h1); chk_pc("c1", 32'h0, 32'h0);
      step(); chk_pc("c2", 32'h4, 32'h0);
      step(); chk_pc("c3", 32'h8, 32'h4); chk("c3_plus", plus_a, 32'hC);
      step(); chk_pc("c4", 32'hC, 32'h8);
      step(); chk_pc("c5", 32'h10, 32'hC);

      // No Fetch_Ready, then Stall: hold
      Fetch_Ready = 1'b0;
      step(); chk_pc("nordy1", 32'h10, 32'hC);
      step(); chk_pc("nordy2", 32'h10, 32'hC);
      Fetch_Ready = 1'b1; Stall = 1'b1;
      step(); chk_pc("stall1", 32'h10, 32'hC);

      // Redirect under stall
      Redirect_Valid = 1'b1; Redirect_Target = 32'h200;
      step(); chk_pc("redir_stall", 32'h200, 32'hC);

      // Trap beats redirect; accept still records previous PC
      Stall = 1'b0; Trap_Valid = 1'b1; Redirect_Target = 32'h300;
      step(); chk_pc("trap_wins", 32'h100, 32'h200);
      chk("trap_err", {31'b0, err_a}, 32'h0);

      // Misaligned redirect
      Trap_Valid = 1'b0; Redirect_Target = 32'h202;
      step(); chk_pc("misal", 32'h100, 32'h100);
      chk("misal_err", {31'b0, err_a}, 32'h1);
      chk("noalign_pc", pc_b, 32'h202);
      chk("noalign_err", {31'b0, err_b}, 32'h0);
      Redirect_Valid = 1'b0; Fetch_Ready = 1'b0;
      step(); chk("misal_err_pulse", {31'b0, err_a}, 32'h0);
      chk("misal_hold", pc_a, 32'h100);
      chk("noalign_hold", pc_b, 32'h202);

      // Halt at 0x40
      Redirect_Valid = 1'b1; Redirect_Target = 32'h40;
      step(); chk("to40", pc_a, 32'h40);
      Redirect_Valid = 1'b0; Halt_Req = 1'b1;
      step(); chk("halt_halted", {31'b0, halted_a}, 32'h1);
      chk("halt_valid", {31'b0, valid_a}, 32'h0);
      chk("halt_pc", pc_a, 32'h40);
      Halt_Req = 1'b0; Fetch_Ready = 1'b1;
      step(); chk("halt_hold_pc", pc_a, 32'h40);
      chk("halt_hold_halted", {31'b0, halted_a}, 32'h1);
      Resume = 1'b1;
      step(); chk("resume_halted", {31'b0, halted_a}, 32'h0);
      chk("resume_valid", {31'b0, valid_a}, 32'h1);
      chk("resume_pc", pc_a, 32'h40);
      Resume = 1'b0;
      step(); chk_pc("resume_fetch", 32'h44, 32'h40);

      // Wrap-around
      Fetch_Ready = 1'b0; Redirect_Valid = 1'b1; Redirect_Target = 32'hFFFF_FFFC;
      step(); chk("wrap_pc", pc_a, 32'hFFFF_FFFC); chk("wrap_plus", plus_a, 32'h0);
      Redirect_Valid = 1'b0; Fetch_Ready = 1'b1;
      step(); chk_pc("wrap", 32'h0, 32'hFFFF_FFFC);

      // Asynchronous reset mid-stream
      Fetch_Ready = 1'b0; Redirect_Valid = 1'b1; Redirect_Target = 32'h80;
      step(); chk("pre_rst_pc", pc_a, 32'h80);
      Redirect_Valid = 1'b0; Fetch_Ready = 1'b1;
      #2 Reset = 1'b1;
      #1;
      chk("arst_pc", pc_a, 32'h0);
      chk("arst_valid", {31'b0, valid_a}, 32'h0);
      chk("arst_prev", prev_a, 32'h0);
      step(); chk("arst_held_pc", pc_a, 32'h0);
      Reset = 1'b0;

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
